// File: rtl/lutram_fifo32x16.sv
// 32x16 first-word-fall-through FIFO on distributed RAM (sync write, async read).
// Status flags are registered from the next count so they always agree with COUNT.
module lutram_fifo32x16 #(
  parameter int unsigned ALMOST_FULL_THR  = 28,
  parameter int unsigned ALMOST_EMPTY_THR = 4,
  parameter bit          IS_CLK_INVERTED  = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        WR_EN,
  input  logic [15:0] WR_DATA,
  input  logic        RD_EN,
  output logic [15:0] RD_DATA,
  output logic        EMPTY,
  output logic        FULL,
  output logic        ALMOST_EMPTY,
  output logic        ALMOST_FULL,
  output logic [5:0]  COUNT,
  output logic        OVERFLOW,
  output logic        UNDERFLOW
);

  localparam logic [5:0] AF_THR = 6'(ALMOST_FULL_THR);
  localparam logic [5:0] AE_THR = 6'(ALMOST_EMPTY_THR);

  // Inverting the clock lets every register share one posedge process.
  logic clk_act;
  assign clk_act = CLK ^ IS_CLK_INVERTED;

  logic [15:0] mem_q [32];
  logic [4:0]  wp_q, wp_d, rp_q, rp_d;
  logic [5:0]  count_q, count_d;
  logic        empty_q, empty_d, full_q, full_d;
  logic        ae_q, ae_d, af_q, af_d;
  logic        ovf_q, ovf_d, unf_q, unf_d;
  logic        wr_acc, rd_acc;

  assign wr_acc = RST_N & WR_EN & ~full_q;
  assign rd_acc = RST_N & RD_EN & ~empty_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (!RST_N) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wp_d = wp_q + 5'd1;
      if (rd_acc) rp_d = rp_q + 5'd1;
      if (wr_acc && !rd_acc)      count_d = count_q + 6'd1;
      else if (rd_acc && !wr_acc) count_d = count_q - 6'd1;
      ovf_d = WR_EN & full_q;
      unf_d = RD_EN & empty_q;
    end
    empty_d = (count_d == 6'd0);
    full_d  = (count_d == 6'd32);
    ae_d    = (count_d <= AE_THR);
    af_d    = (count_d >= AF_THR);
  end

  always_ff @(posedge clk_act) begin
    if (wr_acc) mem_q[wp_q] <= WR_DATA;
  end

  always_ff @(posedge clk_act) begin
    wp_q    <= wp_d;
    rp_q    <= rp_d;
    count_q <= count_d;
    empty_q <= empty_d;
    full_q  <= full_d;
    ae_q    <= ae_d;
    af_q    <= af_d;
    ovf_q   <= ovf_d;
    unf_q   <= unf_d;
  end

  assign RD_DATA      = mem_q[rp_q];
  assign EMPTY        = empty_q;
  assign FULL         = full_q;
  assign ALMOST_EMPTY = ae_q;
  assign ALMOST_FULL  = af_q;
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule
